// File: rtl/mic1_main_memory_pkg.sv
// Shared definitions for the mic1 main-memory responder: state encoding and
// fixed constants used by the top level and its byte RAM.
package mic1_main_memory_pkg;

  localparam int MEM_NBITS        = 32;
  localparam int MEM_BYTE         = 8;
  localparam int MEM_DEPTH_LOG2   = 12;
  localparam int MAX_READ_LATENCY = 3;

  localparam logic [7:0] OOB_READ_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mic1_main_memory_byte_ram.sv
// Single-port byte RAM with synchronous write and a one-cycle registered read.
// A write returns its own data on the read port, so write slots see write-through.
module mic1_main_memory_byte_ram #(
  parameter int DEPTH_LOG2 = 12,
  parameter int BYTE       = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [BYTE-1:0]       wdata,
  output logic [BYTE-1:0]       rdata
);

  logic [BYTE-1:0] mem_q [2**DEPTH_LOG2];
  logic [BYTE-1:0] rdata_q;

  // Storage is deliberately not reset so an image survives a CPU reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
      rdata_q     <= wdata;
    end else begin
      rdata_q     <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mic1_main_memory.sv
// Main memory behind the mic1 memory port: boots an image over a valid/ready
// byte stream, then serves CPU reads/writes with a fixed read latency.
module mic1_main_memory
  import mic1_main_memory_pkg::*;
#(
  parameter int NBITS        = MEM_NBITS,
  parameter int BYTE         = MEM_BYTE,
  parameter int DEPTH_LOG2   = MEM_DEPTH_LOG2,
  parameter int READ_LATENCY = 1,
  parameter int LOAD_ENABLE  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] mem_addr,
  input  logic [BYTE-1:0]  mem_out,
  input  logic             we,
  output logic [BYTE-1:0]  mem_in,
  input  logic             load_valid,
  input  logic [BYTE-1:0]  load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic             run,
  output logic             oob_err
);

  localparam logic [DEPTH_LOG2-1:0] TOP_ADDR = '1;

  mem_state_t            state_q, state_d;
  logic [DEPTH_LOG2-1:0] load_ptr_q, load_ptr_d;
  logic                  load_ready_q, run_q;
  logic                  oob_err_q, oob_err_d;
  logic                  run_slot_q, run_slot_d;
  logic                  oob_slot_q, oob_slot_d;

  logic                  load_accept_s;
  logic                  cpu_oob_s;
  logic                  ram_we_s;
  logic [DEPTH_LOG2-1:0] ram_addr_s;
  logic [BYTE-1:0]       ram_wdata_s;
  logic [BYTE-1:0]       ram_rdata_s;
  logic [BYTE-1:0]       stage0_s;

  assign load_accept_s = load_valid & load_ready_q;
  assign cpu_oob_s     = |mem_addr[NBITS-1:DEPTH_LOG2];

  // Next state and load pointer; the top address ends LOAD so the pointer never wraps.
  always_comb begin
    state_d    = state_q;
    load_ptr_d = load_ptr_q;
    case (state_q)
      IDLE: state_d = (LOAD_ENABLE != 0) ? LOAD : RUN;
      LOAD: begin
        if (load_accept_s) begin
          if (load_last || (load_ptr_q == TOP_ADDR)) begin
            state_d = RUN;
          end else begin
            load_ptr_d = load_ptr_q + DEPTH_LOG2'(1);
          end
        end else begin
          load_ptr_d = load_ptr_q;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // The load stream and the CPU port never own the RAM at the same time.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = mem_addr[DEPTH_LOG2-1:0];
    ram_wdata_s = mem_out;
    if (state_q == LOAD) begin
      ram_we_s    = load_accept_s;
      ram_addr_s  = load_ptr_q;
      ram_wdata_s = load_data;
    end else if (state_q == RUN) begin
      ram_we_s    = we & ~cpu_oob_s;
    end else begin
      ram_we_s    = 1'b0;
    end
  end

  always_comb begin
    run_slot_d = (state_q == RUN);
    oob_slot_d = (state_q == RUN) & cpu_oob_s;
    oob_err_d  = oob_err_q | oob_slot_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      load_ptr_q   <= '0;
      load_ready_q <= 1'b0;
      run_q        <= 1'b0;
      oob_err_q    <= 1'b0;
      run_slot_q   <= 1'b0;
      oob_slot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      load_ready_q <= (state_d == LOAD);
      run_q        <= (state_d == RUN);
      oob_err_q    <= oob_err_d;
      run_slot_q   <= run_slot_d;
      oob_slot_q   <= oob_slot_d;
    end
  end

  mic1_main_memory_byte_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .BYTE       (BYTE)
  ) u_byte_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Slot flags travel with the RAM read so non-RUN slots read as zero.
  always_comb begin
    if (!run_slot_q) begin
      stage0_s = '0;
    end else if (oob_slot_q) begin
      stage0_s = BYTE'(OOB_READ_DATA);
    end else begin
      stage0_s = ram_rdata_s;
    end
  end

  if (READ_LATENCY > 1) begin : g_pipe
    logic [BYTE-1:0] pipe_q [READ_LATENCY-1];
    logic [BYTE-1:0] pipe_d [READ_LATENCY-1];

    always_comb begin
      pipe_d[0] = stage0_s;
      for (int i = 1; i < READ_LATENCY - 1; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    // Extra delay stages; cleared on reset so stale reads are discarded.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign mem_in = pipe_q[READ_LATENCY-2];
  end else begin : g_direct
    assign mem_in = stage0_s;
  end

  assign load_ready = load_ready_q;
  assign run        = run_q;
  assign oob_err    = oob_err_q;

endmodule
